// File: rtl/vx_warp_ctl_unit_pkg.sv
// Shared warp-control types: op codes, per-op control payloads and sizing constants.
// Used by vx_warp_ctl_unit and vx_barrier_table.
package gpu_types;

    localparam int unsigned NUM_THREADS  = 4;
    localparam int unsigned NUM_WARPS    = 4;
    localparam int unsigned NUM_BARRIERS = 4;
    localparam int unsigned GPU_OP_BITS  = 3;

    localparam int unsigned NT_BITS  = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
    localparam int unsigned NW_BITS  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int unsigned NB_BITS  = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;
    localparam int unsigned CNT_BITS = $clog2(NUM_WARPS + 1);

    typedef enum logic [GPU_OP_BITS-1:0] {
        OpTmc    = 3'd0,
        OpWspawn = 3'd1,
        OpSplit  = 3'd2,
        OpBar    = 3'd4,
        OpPred   = 3'd5
    } gpu_op_e;

    typedef struct packed {
        logic                   valid;
        logic [NUM_THREADS-1:0] tmask;
    } gpu_tmc_t;

    typedef struct packed {
        logic                 valid;
        logic [NUM_WARPS-1:0] wmask;
        logic [31:0]          pc;
    } gpu_wspawn_t;

    typedef struct packed {
        logic                   valid;
        logic                   diverged;
        logic [NUM_THREADS-1:0] then_tmask;
        logic [NUM_THREADS-1:0] else_tmask;
        logic [31:0]            pc;
    } gpu_split_t;

    // A barrier entry releases when valid & !stall.
    typedef struct packed {
        logic                 valid;
        logic [NB_BITS-1:0]   id;
        logic                 stall;
        logic [NUM_WARPS-1:0] release_wmask;
    } gpu_barrier_t;

    // Warps 0..n-1 spawn; n beyond NUM_WARPS saturates to all-ones.
    function automatic logic [NUM_WARPS-1:0] spawn_mask(input logic [31:0] n);
        logic [NUM_WARPS-1:0] m;
        m = '0;
        for (int i = 0; i < int'(NUM_WARPS); i++) begin
            m[i] = (32'(i) < n);
        end
        return m;
    endfunction

    function automatic logic [CNT_BITS-1:0] barrier_size(input logic [31:0] n);
        return (n > 32'(NUM_WARPS)) ? CNT_BITS'(NUM_WARPS) : n[CNT_BITS-1:0];
    endfunction

endpackage

// File: rtl/vx_warp_ctl_unit_barrier_table.sv
// Barrier table: per-id arrived-warp mask and arrival count, with the release decision for
// the barrier currently being issued. State updates only on an accepted arrival.
module vx_barrier_table
    import gpu_types::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 arrive,
    input  logic [NB_BITS-1:0]   bar_id,
    input  logic [NW_BITS-1:0]   bar_wid,
    input  logic [CNT_BITS-1:0]  bar_size,
    output logic                 stall,
    output logic [NUM_WARPS-1:0] release_wmask
);

    logic [NUM_WARPS-1:0] arrived_q [NUM_BARRIERS];
    logic [NUM_WARPS-1:0] arrived_d [NUM_BARRIERS];
    logic [CNT_BITS-1:0]  count_q   [NUM_BARRIERS];
    logic [CNT_BITS-1:0]  count_d   [NUM_BARRIERS];

    logic [NUM_WARPS-1:0] self_mask;
    logic [NUM_WARPS-1:0] merged_mask;
    logic [CNT_BITS-1:0]  new_count;
    logic                 done;

    always_comb begin
        self_mask          = '0;
        self_mask[bar_wid] = 1'b1;
        merged_mask        = arrived_q[bar_id] | self_mask;
        // A warp re-arriving at the same barrier must not be counted twice.
        new_count          = count_q[bar_id] + CNT_BITS'(!arrived_q[bar_id][bar_wid]);
        done               = (new_count >= bar_size);
        stall              = !done;
        release_wmask      = done ? merged_mask : '0;

        arrived_d = arrived_q;
        count_d   = count_q;
        if (arrive) begin
            if (done) begin
                arrived_d[bar_id] = '0;
                count_d[bar_id]   = '0;
            end else begin
                arrived_d[bar_id] = merged_mask;
                count_d[bar_id]   = new_count;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            arrived_q <= '{default: '0};
            count_q   <= '{default: '0};
        end else begin
            arrived_q <= arrived_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: rtl/vx_warp_ctl_unit.sv
// Warp-control execute unit: decodes control ops into a response FIFO and drives commit plus
// warp-control payloads from its head. Define WCTL_PERF_EN to add per-op performance counters.
module vx_warp_ctl_unit
    import gpu_types::*;
#(
    parameter int unsigned RSP_DEPTH = 2,
    parameter int unsigned UUID_BITS = 44
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [UUID_BITS-1:0]       req_uuid,
    input  logic [NW_BITS-1:0]         req_wid,
    input  logic [NUM_THREADS-1:0]     req_tmask,
    input  logic [31:0]                req_PC,
    input  logic [31:0]                req_next_PC,
    input  logic [GPU_OP_BITS-1:0]     req_op,
    input  logic [NT_BITS-1:0]         req_tid,
    input  logic [NUM_THREADS*32-1:0]  req_rs1,
    input  logic [NUM_THREADS*32-1:0]  req_rs2,

`ifdef WCTL_PERF_EN
    output logic [31:0]                perf_tmc,
    output logic [31:0]                perf_wspawn,
    output logic [31:0]                perf_split,
    output logic [31:0]                perf_bar,
    output logic [31:0]                perf_stall,
`endif

    output logic                       cmt_valid,
    input  logic                       cmt_ready,
    output logic [UUID_BITS-1:0]       cmt_uuid,
    output logic [NW_BITS-1:0]         cmt_wid,
    output logic [NUM_THREADS-1:0]     cmt_tmask,
    output logic [31:0]                cmt_PC,
    output logic                       cmt_eop,

    output logic                       wctl_valid,
    output logic [NW_BITS-1:0]         wctl_wid,
    output gpu_tmc_t                   wctl_tmc,
    output gpu_wspawn_t                wctl_wspawn,
    output gpu_split_t                 wctl_split,
    output gpu_barrier_t               wctl_barrier
);

    localparam int unsigned PTR_BITS = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned FC_BITS  = $clog2(RSP_DEPTH + 1);

    typedef struct packed {
        logic [UUID_BITS-1:0]   uuid;
        logic [NW_BITS-1:0]     wid;
        logic [NUM_THREADS-1:0] tmask;
        logic [31:0]            pc;
        logic                   is_ctl;
        gpu_tmc_t               tmc;
        gpu_wspawn_t            wspawn;
        gpu_split_t             split;
        gpu_barrier_t           barrier;
    } rsp_entry_t;

    rsp_entry_t           mem_q [RSP_DEPTH];
    rsp_entry_t           mem_d [RSP_DEPTH];
    logic [PTR_BITS-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FC_BITS-1:0]   count_q, count_d;

    logic [31:0]            rs1_lane [NUM_THREADS];
    logic [31:0]            rs2_lane [NUM_THREADS];
    logic [31:0]            rs1_s;
    logic [31:0]            rs2_s;
    logic [NUM_THREADS-1:0] taken;
    logic [NUM_THREADS-1:0] pred_taken;
    logic                   push;
    logic                   pop;
    logic                   bar_arrive;
    logic                   bar_stall;
    logic [NUM_WARPS-1:0]   bar_release_wmask;
    rsp_entry_t             new_entry;
    rsp_entry_t             head;

    always_comb begin
        for (int i = 0; i < int'(NUM_THREADS); i++) begin
            rs1_lane[i] = req_rs1[i*32 +: 32];
            rs2_lane[i] = req_rs2[i*32 +: 32];
            taken[i]    = |req_rs1[i*32 +: 32];
        end
        rs1_s      = rs1_lane[req_tid];
        rs2_s      = rs2_lane[req_tid];
        pred_taken = req_tmask & taken;
    end

    assign push       = req_valid & req_ready;
    assign pop        = cmt_valid & cmt_ready;
    assign bar_arrive = push & (req_op == OpBar);

    vx_barrier_table u_barrier_table (
        .clk           (clk),
        .reset         (reset),
        .arrive        (bar_arrive),
        .bar_id        (rs1_s[NB_BITS-1:0]),
        .bar_wid       (req_wid),
        .bar_size      (barrier_size(rs2_s)),
        .stall         (bar_stall),
        .release_wmask (bar_release_wmask)
    );

    always_comb begin
        new_entry       = '0;
        new_entry.uuid  = req_uuid;
        new_entry.wid   = req_wid;
        new_entry.tmask = req_tmask;
        new_entry.pc    = req_PC;
        case (req_op)
            OpTmc: begin
                new_entry.is_ctl    = 1'b1;
                new_entry.tmc.valid = 1'b1;
                new_entry.tmc.tmask = rs1_s[NUM_THREADS-1:0];
            end
            OpPred: begin
                // No lane taken keeps the original mask so the warp never goes fully idle.
                new_entry.is_ctl    = 1'b1;
                new_entry.tmc.valid = 1'b1;
                new_entry.tmc.tmask = (|pred_taken) ? pred_taken : req_tmask;
            end
            OpWspawn: begin
                new_entry.is_ctl       = 1'b1;
                new_entry.wspawn.valid = 1'b1;
                new_entry.wspawn.wmask = spawn_mask(rs1_s);
                new_entry.wspawn.pc    = rs2_s;
            end
            OpSplit: begin
                new_entry.is_ctl           = 1'b1;
                new_entry.split.valid      = 1'b1;
                new_entry.split.then_tmask = req_tmask & taken;
                new_entry.split.else_tmask = req_tmask & ~taken;
                new_entry.split.diverged   = (|(req_tmask & taken)) & (|(req_tmask & ~taken));
                new_entry.split.pc         = req_next_PC;
            end
            OpBar: begin
                new_entry.is_ctl                = 1'b1;
                new_entry.barrier.valid         = 1'b1;
                new_entry.barrier.id            = rs1_s[NB_BITS-1:0];
                new_entry.barrier.stall         = bar_stall;
                new_entry.barrier.release_wmask = bar_release_wmask;
            end
            default: ;
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + FC_BITS'(push) - FC_BITS'(pop);
        if (push) begin
            mem_d[wr_ptr_q] = new_entry;
            wr_ptr_d = (wr_ptr_q == PTR_BITS'(RSP_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_BITS'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_BITS'(RSP_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Ready is gated by reset so it drops immediately and returns in the first free cycle.
    assign req_ready = reset & (count_q < FC_BITS'(RSP_DEPTH));
    assign cmt_valid = (count_q != '0);
    assign head      = cmt_valid ? mem_q[rd_ptr_q] : '0;

    assign cmt_uuid     = head.uuid;
    assign cmt_wid      = head.wid;
    assign cmt_tmask    = head.tmask;
    assign cmt_PC       = head.pc;
    assign cmt_eop      = 1'b1;
    assign wctl_valid   = pop & head.is_ctl;
    assign wctl_wid     = head.wid;
    assign wctl_tmc     = head.tmc;
    assign wctl_wspawn  = head.wspawn;
    assign wctl_split   = head.split;
    assign wctl_barrier = head.barrier;

`ifdef WCTL_PERF_EN
    logic [31:0] perf_tmc_q, perf_tmc_d;
    logic [31:0] perf_wspawn_q, perf_wspawn_d;
    logic [31:0] perf_split_q, perf_split_d;
    logic [31:0] perf_bar_q, perf_bar_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_tmc_d    = perf_tmc_q + 32'(push & (req_op == OpTmc));
        perf_wspawn_d = perf_wspawn_q + 32'(push & (req_op == OpWspawn));
        perf_split_d  = perf_split_q + 32'(push & (req_op == OpSplit));
        perf_bar_d    = perf_bar_q + 32'(bar_arrive);
        perf_stall_d  = perf_stall_q + 32'(cmt_valid & !cmt_ready);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_tmc_q    <= '0;
            perf_wspawn_q <= '0;
            perf_split_q  <= '0;
            perf_bar_q    <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_tmc_q    <= perf_tmc_d;
            perf_wspawn_q <= perf_wspawn_d;
            perf_split_q  <= perf_split_d;
            perf_bar_q    <= perf_bar_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_tmc    = perf_tmc_q;
    assign perf_wspawn = perf_wspawn_q;
    assign perf_split  = perf_split_q;
    assign perf_bar    = perf_bar_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_vx_warp_ctl_unit.sv
// Directed bench for vx_warp_ctl_unit: TMC/PRED, SPLIT, WSPAWN, barrier, back-pressure, reset.
module tb_vx_warp_ctl_unit;
    import gpu_types::*;

    localparam int unsigned RSP_DEPTH = 2;
    localparam int unsigned UUID_BITS = 44;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      req_valid;
    logic                      req_ready;
    logic [UUID_BITS-1:0]      req_uuid;
    logic [NW_BITS-1:0]        req_wid;
    logic [NUM_THREADS-1:0]    req_tmask;
    logic [31:0]               req_PC;
    logic [31:0]               req_next_PC;
    logic [GPU_OP_BITS-1:0]    req_op;
    logic [NT_BITS-1:0]        req_tid;
    logic [NUM_THREADS*32-1:0] req_rs1;
    logic [NUM_THREADS*32-1:0] req_rs2;
    logic                      cmt_valid;
    logic                      cmt_ready;
    logic [UUID_BITS-1:0]      cmt_uuid;
    logic [NW_BITS-1:0]        cmt_wid;
    logic [NUM_THREADS-1:0]    cmt_tmask;
    logic [31:0]               cmt_PC;
    logic                      cmt_eop;
    logic                      wctl_valid;
    logic [NW_BITS-1:0]        wctl_wid;
    gpu_tmc_t                  wctl_tmc;
    gpu_wspawn_t               wctl_wspawn;
    gpu_split_t                wctl_split;
    gpu_barrier_t              wctl_barrier;
`ifdef WCTL_PERF_EN
    logic [31:0] perf_tmc, perf_wspawn, perf_split, perf_bar, perf_stall;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    vx_warp_ctl_unit #(
        .RSP_DEPTH (RSP_DEPTH),
        .UUID_BITS (UUID_BITS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_uuid     (req_uuid),
        .req_wid      (req_wid),
        .req_tmask    (req_tmask),
        .req_PC       (req_PC),
        .req_next_PC  (req_next_PC),
        .req_op       (req_op),
        .req_tid      (req_tid),
        .req_rs1      (req_rs1),
        .req_rs2      (req_rs2),
`ifdef WCTL_PERF_EN
        .perf_tmc     (perf_tmc),
        .perf_wspawn  (perf_wspawn),
        .perf_split   (perf_split),
        .perf_bar     (perf_bar),
        .perf_stall   (perf_stall),
`endif
        .cmt_valid    (cmt_valid),
        .cmt_ready    (cmt_ready),
        .cmt_uuid     (cmt_uuid),
        .cmt_wid      (cmt_wid),
        .cmt_tmask    (cmt_tmask),
        .cmt_PC       (cmt_PC),
        .cmt_eop      (cmt_eop),
        .wctl_valid   (wctl_valid),
        .wctl_wid     (wctl_wid),
        .wctl_tmc     (wctl_tmc),
        .wctl_wspawn  (wctl_wspawn),
        .wctl_split   (wctl_split),
        .wctl_barrier (wctl_barrier)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NUM_THREADS*32-1:0] lanes(input logic [31:0] l3, input logic [31:0] l2,
                                                        input logic [31:0] l1, input logic [31:0] l0);
        return {l3, l2, l1, l0};
    endfunction

    task automatic drive(input logic [GPU_OP_BITS-1:0] op, input logic [NW_BITS-1:0] wid,
                         input logic [NUM_THREADS-1:0] tmask, input logic [NT_BITS-1:0] tid,
                         input logic [NUM_THREADS*32-1:0] rs1, input logic [NUM_THREADS*32-1:0] rs2,
                         input logic [UUID_BITS-1:0] uuid);
        req_valid   = 1'b1;
        req_op      = op;
        req_wid     = wid;
        req_tmask   = tmask;
        req_tid     = tid;
        req_rs1     = rs1;
        req_rs2     = rs2;
        req_uuid    = uuid;
        req_PC      = 32'h200 + 32'(uuid);
        req_next_PC = 32'h204 + 32'(uuid);
    endtask

    // One request accepted on the next edge; entry sits at the head afterwards.
    task automatic send(input logic [GPU_OP_BITS-1:0] op, input logic [NW_BITS-1:0] wid,
                        input logic [NUM_THREADS-1:0] tmask, input logic [NT_BITS-1:0] tid,
                        input logic [NUM_THREADS*32-1:0] rs1, input logic [NUM_THREADS*32-1:0] rs2,
                        input logic [UUID_BITS-1:0] uuid);
        drive(op, wid, tmask, tid, rs1, rs2, uuid);
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = 1'b0;
        cmt_ready = 1'b1;
        drive(3'd3, 2'd0, 4'b0000, 2'd0, '0, '0, '0);
        req_valid = 1'b0;
        #2;
        check("rst_ready",      64'(req_ready), 64'd0);
        check("rst_cmt_valid",  64'(cmt_valid), 64'd0);
        check("rst_wctl_valid", 64'(wctl_valid), 64'd0);
        check("rst_uuid",       64'(cmt_uuid), 64'd0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("rst_ready_after", 64'(req_ready), 64'd1);

        // TMC: tid=1 lane carries 5
        send(OpTmc, 2'd1, 4'b1111, 2'd1, lanes(0, 0, 5, 0), '0, 44'd1);
        check("tmc_cmt_valid",  64'(cmt_valid), 64'd1);
        check("tmc_wctl_valid", 64'(wctl_valid), 64'd1);
        check("tmc_wid",        64'(wctl_wid), 64'd1);
        check("tmc_valid",      64'(wctl_tmc.valid), 64'd1);
        check("tmc_tmask",      64'(wctl_tmc.tmask), 64'b0101);
        check("tmc_uuid",       64'(cmt_uuid), 64'd1);
        check("tmc_cmt_tmask",  64'(cmt_tmask), 64'b1111);
        check("tmc_pc",         64'(cmt_PC), 64'h201);
        check("tmc_eop",        64'(cmt_eop), 64'd1);
        tick();
        check("tmc_popped",     64'(cmt_valid), 64'd0);

        // PRED: taken lanes 2,3 masked by 0111 -> 0100; none taken keeps mask
        send(OpPred, 2'd2, 4'b0111, 2'd0, lanes(9, 1, 0, 0), '0, 44'd2);
        check("pred_tmask", 64'(wctl_tmc.tmask), 64'b0100);
        tick();
        send(OpPred, 2'd2, 4'b0110, 2'd0, '0, '0, 44'd3);
        check("pred_keep",  64'(wctl_tmc.tmask), 64'b0110);
        tick();

        // SPLIT: lanes 1 and 3 taken
        send(OpSplit, 2'd0, 4'b1111, 2'd0, lanes(3, 0, 7, 0), '0, 44'd4);
        check("split_then", 64'(wctl_split.then_tmask), 64'b1010);
        check("split_else", 64'(wctl_split.else_tmask), 64'b0101);
        check("split_div",  64'(wctl_split.diverged), 64'd1);
        check("split_pc",   64'(wctl_split.pc), 64'h208);
        tick();
        send(OpSplit, 2'd0, 4'b1111, 2'd0, '0, '0, 44'd5);
        check("split_div0",  64'(wctl_split.diverged), 64'd0);
        check("split_else0", 64'(wctl_split.else_tmask), 64'b1111);
        tick();

        // WSPAWN on lane 2
        send(OpWspawn, 2'd0, 4'b1111, 2'd2, lanes(0, 9, 0, 0), lanes(0, 32'h80, 0, 0), 44'd6);
        check("wspawn_mask_sat", 64'(wctl_wspawn.wmask), 64'b1111);
        check("wspawn_pc",       64'(wctl_wspawn.pc), 64'h80);
        tick();
        send(OpWspawn, 2'd0, 4'b1111, 2'd2, lanes(0, 2, 0, 0), '0, 44'd7);
        check("wspawn_mask2",    64'(wctl_wspawn.wmask), 64'b0011);
        tick();
        send(OpWspawn, 2'd0, 4'b1111, 2'd2, '0, '0, 44'd8);
        check("wspawn_mask0",    64'(wctl_wspawn.wmask), 64'b0000);
        tick();

        // BAR id = 6 mod 4 = 2, size 3; back-to-back w0, w1, w0, w3
        drive(OpBar, 2'd0, 4'b1111, 2'd0, lanes(0, 0, 0, 6), lanes(0, 0, 0, 3), 44'd20);
        tick();
        check("bar0_id",    64'(wctl_barrier.id), 64'd2);
        check("bar0_stall", 64'(wctl_barrier.stall), 64'd1);
        check("bar0_mask",  64'(wctl_barrier.release_wmask), 64'd0);
        drive(OpBar, 2'd1, 4'b1111, 2'd0, lanes(0, 0, 0, 6), lanes(0, 0, 0, 3), 44'd21);
        tick();
        check("bar1_uuid",  64'(cmt_uuid), 64'd21);
        check("bar1_stall", 64'(wctl_barrier.stall), 64'd1);
        drive(OpBar, 2'd0, 4'b1111, 2'd0, lanes(0, 0, 0, 6), lanes(0, 0, 0, 3), 44'd22);
        tick();
        check("bar2_stall_recount", 64'(wctl_barrier.stall), 64'd1);
        drive(OpBar, 2'd3, 4'b1111, 2'd0, lanes(0, 0, 0, 6), lanes(0, 0, 0, 3), 44'd23);
        tick();
        req_valid = 1'b0;
        check("bar3_stall", 64'(wctl_barrier.stall), 64'd0);
        check("bar3_mask",  64'(wctl_barrier.release_wmask), 64'b1011);
        check("bar3_wctl",  64'(wctl_valid), 64'd1);
        tick();
        send(OpBar, 2'd1, 4'b1111, 2'd0, lanes(0, 0, 0, 2), lanes(0, 0, 0, 2), 44'd24);
        check("bar_cleared_stall", 64'(wctl_barrier.stall), 64'd1);
        check("bar_cleared_mask",  64'(wctl_barrier.release_wmask), 64'd0);
        tick();
        send(OpBar, 2'd2, 4'b1111, 2'd0, lanes(0, 0, 0, 2), lanes(0, 0, 0, 2), 44'd25);
        check("bar_size2_mask", 64'(wctl_barrier.release_wmask), 64'b0110);
        tick();
        send(OpBar, 2'd3, 4'b1111, 2'd0, lanes(0, 0, 0, 1), '0, 44'd26);
        check("bar_size0_stall", 64'(wctl_barrier.stall), 64'd0);
        check("bar_size0_mask",  64'(wctl_barrier.release_wmask), 64'b1000);
        tick();

        // Back-pressure: non-control op fills the 2-entry FIFO
        cmt_ready = 1'b0;
        drive(3'd3, 2'd0, 4'b0001, 2'd0, '0, '0, 44'd10);
        check("bp_ready0", 64'(req_ready), 64'd1);
        tick();
        drive(3'd3, 2'd0, 4'b0001, 2'd0, '0, '0, 44'd11);
        tick();
        drive(3'd3, 2'd0, 4'b0001, 2'd0, '0, '0, 44'd12);
        check("bp_full_ready", 64'(req_ready), 64'd0);
        check("bp_head",       64'(cmt_uuid), 64'd10);
        check("bp_wctl",       64'(wctl_valid), 64'd0);
        tick();
        tick();
        check("bp_head_held",  64'(cmt_uuid), 64'd10);
        check("bp_still_full", 64'(req_ready), 64'd0);
        cmt_ready = 1'b1;
        #1;
        check("bp_no_bypass",  64'(req_ready), 64'd0);
        check("bp_nonctl",     64'(wctl_valid), 64'd0);
        tick();
        check("bp_head11",     64'(cmt_uuid), 64'd11);
        check("bp_ready_back", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        check("bp_head12",     64'(cmt_uuid), 64'd12);
        tick();
        check("bp_drained",    64'(cmt_valid), 64'd0);

        // Reset mid-barrier: w0 arrives at id0 (size 3), entry left pending
        cmt_ready = 1'b0;
        send(OpBar, 2'd0, 4'b1111, 2'd0, '0, lanes(0, 0, 0, 3), 44'd30);
        check("rb_stall", 64'(wctl_barrier.stall), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("rb_cmt_valid", 64'(cmt_valid), 64'd0);
        check("rb_ready",     64'(req_ready), 64'd0);
        tick();
        reset     = 1'b1;
        cmt_ready = 1'b1;
        #1;
        check("rb_ready_after", 64'(req_ready), 64'd1);
        check("rb_empty",       64'(cmt_valid), 64'd0);
`ifdef WCTL_PERF_EN
        check("perf_tmc",    64'(perf_tmc), 64'd0);
        check("perf_wspawn", 64'(perf_wspawn), 64'd0);
        check("perf_split",  64'(perf_split), 64'd0);
        check("perf_bar",    64'(perf_bar), 64'd0);
        check("perf_stall",  64'(perf_stall), 64'd0);
`endif
        send(OpBar, 2'd1, 4'b1111, 2'd0, '0, lanes(0, 0, 0, 2), 44'd31);
        check("rb_w1_stall", 64'(wctl_barrier.stall), 64'd1);
        check("rb_w1_mask",  64'(wctl_barrier.release_wmask), 64'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
